// File: rtl/data_memory_responder_if.sv
// Request/response bundle between the memory-access stage (master) and the
// data RAM model (slave). resp_err exists only when MEM_RANGE_CHECK_EN is defined.
interface data_memory_responder_if #(
    parameter int DataWidth = 32,
    parameter int AddrWidth = 32,
    parameter int WordSize  = 4
);
    logic                 req_valid;
    logic                 req_ready;
    logic [AddrWidth-1:0] address;
    logic                 read_enable;
    logic                 write_enable;
    logic [WordSize-1:0]  write_strobe;
    logic [DataWidth-1:0] write_data;
    logic [DataWidth-1:0] read_data;
    logic                 resp_valid;
`ifdef MEM_RANGE_CHECK_EN
    logic                 resp_err;

    modport master (
        output req_valid, address, read_enable, write_enable, write_strobe, write_data,
        input  req_ready, read_data, resp_valid, resp_err
    );

    modport slave (
        input  req_valid, address, read_enable, write_enable, write_strobe, write_data,
        output req_ready, read_data, resp_valid, resp_err
    );
`else
    modport master (
        output req_valid, address, read_enable, write_enable, write_strobe, write_data,
        input  req_ready, read_data, resp_valid
    );

    modport slave (
        input  req_valid, address, read_enable, write_enable, write_strobe, write_data,
        output req_ready, read_data, resp_valid
    );
`endif
endinterface

// File: rtl/data_memory_responder.sv
// Data RAM responder: word storage with byte-strobed writes, read-before-write on
// combined requests and a programmable number of wait states per request.
// Optional macro MEM_RANGE_CHECK_EN: flags addresses above the storage range with
// resp_err and suppresses their effect; otherwise upper address bits alias.
module data_memory_responder #(
    parameter int DataWidth  = 32,
    parameter int AddrWidth  = 32,
    parameter int WordSize   = 4,
    parameter int ByteBits   = 8,
    parameter int DepthWords = 1024,
    parameter int WaitStates = 2
) (
    input  logic                    clk,
    input  logic                    rst,
    data_memory_responder_if.slave  bus
);
    localparam int IdxW = $clog2(DepthWords);

`ifdef MEM_RANGE_CHECK_EN
    localparam bit RangeCheck = 1'b1;
`else
    localparam bit RangeCheck = 1'b0;
`endif

    typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

    state_t               state, next_state;
    logic [3:0]           wait_cnt;
    logic                 req_ready_int;
    logic                 resp_valid_int;
    logic                 accept;
    logic                 commit;

    // latched request
    logic [AddrWidth-1:0] lat_addr;
    logic                 lat_re;
    logic                 lat_we;
    logic [WordSize-1:0]  lat_strb;
    logic [DataWidth-1:0] lat_wdata;

    // commit source: live inputs when jumping straight from IDLE, latched otherwise
    logic [AddrWidth-1:0] src_addr;
    logic                 src_re;
    logic                 src_we;
    logic [WordSize-1:0]  src_strb;
    logic [DataWidth-1:0] src_wdata;
    logic [IdxW-1:0]      src_idx;
    logic                 src_err;
    logic                 lat_err;

    logic [DataWidth-1:0] read_data_q;
    logic [DataWidth-1:0] mem [DepthWords];

    // Replace only the byte lanes selected by the strobe.
    function automatic logic [DataWidth-1:0] merge_lanes(
        input logic [DataWidth-1:0] old_word,
        input logic [DataWidth-1:0] new_word,
        input logic [WordSize-1:0]  strb
    );
        logic [DataWidth-1:0] res;
        res = old_word;
        for (int i = 0; i < WordSize; i++) begin
            if (strb[i]) res[i*ByteBits +: ByteBits] = new_word[i*ByteBits +: ByteBits];
        end
        return res;
    endfunction

    // Any set bit above the word-index field is out of range.
    function automatic logic out_of_range(input logic [AddrWidth-1:0] a);
        return RangeCheck && (|a[AddrWidth-1:IdxW+2]);
    endfunction

    assign accept = bus.req_valid && req_ready_int;

    // Select the request fields used by the storage access.
    always_comb begin
        if (state == IDLE) begin
            src_addr  = bus.address;
            src_re    = bus.read_enable;
            src_we    = bus.write_enable;
            src_strb  = bus.write_strobe;
            src_wdata = bus.write_data;
        end else begin
            src_addr  = lat_addr;
            src_re    = lat_re;
            src_we    = lat_we;
            src_strb  = lat_strb;
            src_wdata = lat_wdata;
        end
        src_idx = src_addr[IdxW+1:2];
        src_err = out_of_range(src_addr);
        lat_err = out_of_range(lat_addr);
    end

    // State register.
    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= next_state;
    end

    // Next-state logic.
    always_comb begin
        next_state = state;
        case (state)
            IDLE:    if (accept) next_state = (WaitStates == 0) ? RESP : WAIT;
            WAIT:    if (wait_cnt <= 4'd1) next_state = RESP;
            RESP:    next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    // Handshake outputs; forced low while reset is held.
    always_comb begin
        req_ready_int  = (state == IDLE) && !rst;
        resp_valid_int = (state == RESP) && !rst;
        commit         = (next_state == RESP) && (state != RESP) && !rst;
    end

    assign bus.req_ready  = req_ready_int;
    assign bus.resp_valid = resp_valid_int;
    assign bus.read_data  = read_data_q;
`ifdef MEM_RANGE_CHECK_EN
    assign bus.resp_err   = resp_valid_int && lat_err;
`endif

    // Wait-state counter: loaded on accept, counts down while waiting.
    always_ff @(posedge clk) begin
        if (rst)                wait_cnt <= 4'd0;
        else if (accept)        wait_cnt <= 4'(WaitStates);
        else if (state == WAIT) wait_cnt <= wait_cnt - 4'd1;
    end

    // Capture the request fields at the handshake.
    always_ff @(posedge clk) begin
        if (accept) begin
            lat_addr  <= bus.address;
            lat_re    <= bus.read_enable;
            lat_we    <= bus.write_enable;
            lat_strb  <= bus.write_strobe;
            lat_wdata <= bus.write_data;
        end
    end

    // Read port: pre-write word on a read, zero otherwise; held until the next commit.
    always_ff @(posedge clk) begin
        if (rst)
            read_data_q <= '0;
        else if (commit)
            read_data_q <= (src_re && !src_err) ? mem[src_idx] : '0;
    end

    // Write port: storage is never reset.
    always_ff @(posedge clk) begin
        if (commit && src_we && !src_err)
            mem[src_idx] <= merge_lanes(mem[src_idx], src_wdata, src_strb);
    end
endmodule

// File: tb/tb_data_memory_responder.sv
// Directed bench for data_memory_responder (WaitStates=2, DepthWords=1024).
module tb_data_memory_responder;
    logic clk;
    logic rst;
    int   vectors;
    int   miscompares;

    data_memory_responder_if #(.DataWidth(32), .AddrWidth(32), .WordSize(4)) ifc ();

    data_memory_responder #(
        .DataWidth(32), .AddrWidth(32), .WordSize(4), .ByteBits(8),
        .DepthWords(1024), .WaitStates(2)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (ifc.slave)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #400000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // One request; returns read_data at the response, latency in cycles after the
    // accepting edge, whether resp_valid dropped the next cycle, and resp_err.
    task automatic do_req(input logic [31:0] a, input logic re, input logic we,
                          input logic [3:0] s, input logic [31:0] wd,
                          output logic [31:0] rd, output int lat,
                          output logic single, output logic err);
        @(negedge clk);
        ifc.req_valid    = 1'b1;
        ifc.address      = a;
        ifc.read_enable  = re;
        ifc.write_enable = we;
        ifc.write_strobe = s;
        ifc.write_data   = wd;
        for (int i = 0; i < 20 && !ifc.req_ready; i++) @(negedge clk);
        @(posedge clk);
        #1;
        ifc.req_valid    = 1'b0;
        ifc.read_enable  = 1'b0;
        ifc.write_enable = 1'b0;
        lat = 0;
        do begin
            @(negedge clk);
            lat++;
        end while (!ifc.resp_valid && lat < 20);
        rd = ifc.read_data;
`ifdef MEM_RANGE_CHECK_EN
        err = ifc.resp_err;
`else
        err = 1'b0;
`endif
        @(negedge clk);
        single = !ifc.resp_valid;
    endtask

    logic [31:0] rd;
    int          lat;
    logic        single;
    logic        err;
    int          pulses;
    int          np;
    int          na;
    int          ready_hi;
    int          pulse_cyc [3];
    logic [31:0] pulse_dat [3];
    logic        took;

    initial begin
        vectors          = 0;
        miscompares      = 0;
        rst              = 1'b1;
        ifc.req_valid    = 1'b0;
        ifc.address      = '0;
        ifc.read_enable  = 1'b0;
        ifc.write_enable = 1'b0;
        ifc.write_strobe = '0;
        ifc.write_data   = '0;

        // reset held for three cycles
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("rst_ready", 32'(ifc.req_ready), 32'd0);
            chk("rst_resp_valid", 32'(ifc.resp_valid), 32'd0);
        end
        chk("rst_read_data", ifc.read_data, 32'h0);
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("ready_after_rst", 32'(ifc.req_ready), 32'd1);

        // full-word write then read
        do_req(32'h10, 1'b0, 1'b1, 4'hF, 32'hDEADBEEF, rd, lat, single, err);
        chk("wr10_latency", 32'(lat), 32'd3);
        chk("wr10_single_pulse", 32'(single), 32'd1);
        do_req(32'h10, 1'b1, 1'b0, 4'h0, 32'h0, rd, lat, single, err);
        chk("rd10_latency", 32'(lat), 32'd3);
        chk("rd10_data", rd, 32'hDEADBEEF);
        chk("rd10_single_pulse", 32'(single), 32'd1);
        repeat (3) @(negedge clk);
        chk("read_data_hold", ifc.read_data, 32'hDEADBEEF);

        // neither enable: no storage change, read_data zero
        do_req(32'h10, 1'b0, 1'b0, 4'hF, 32'h0, rd, lat, single, err);
        chk("noop_latency", 32'(lat), 32'd3);
        chk("noop_read_data", rd, 32'h0);

        // write with zero strobe leaves the word alone
        do_req(32'h10, 1'b0, 1'b1, 4'h0, 32'hFFFFFFFF, rd, lat, single, err);
        chk("strb0_latency", 32'(lat), 32'd3);
        do_req(32'h10, 1'b1, 1'b0, 4'h0, 32'h0, rd, lat, single, err);
        chk("strb0_unchanged", rd, 32'hDEADBEEF);

        // byte-lane write, misaligned read address
        do_req(32'h20, 1'b0, 1'b1, 4'hF, 32'h11223344, rd, lat, single, err);
        do_req(32'h20, 1'b0, 1'b1, 4'b0010, 32'h0000AA00, rd, lat, single, err);
        do_req(32'h21, 1'b1, 1'b0, 4'h0, 32'h0, rd, lat, single, err);
        chk("lane_merge", rd, 32'h1122AA44);

        // read and write together returns the pre-write word
        do_req(32'h40, 1'b0, 1'b1, 4'hF, 32'h01020304, rd, lat, single, err);
        do_req(32'h40, 1'b1, 1'b1, 4'b1100, 32'hFFFFFFFF, rd, lat, single, err);
        chk("rbw_old_word", rd, 32'h01020304);
        do_req(32'h40, 1'b1, 1'b0, 4'h0, 32'h0, rd, lat, single, err);
        chk("rbw_new_word", rd, 32'hFFFF0304);

        // reset during WAIT aborts the write
        do_req(32'h30, 1'b0, 1'b1, 4'hF, 32'hCAFEF00D, rd, lat, single, err);
        @(negedge clk);
        ifc.req_valid    = 1'b1;
        ifc.address      = 32'h30;
        ifc.read_enable  = 1'b0;
        ifc.write_enable = 1'b1;
        ifc.write_strobe = 4'hF;
        ifc.write_data   = 32'h00000055;
        @(posedge clk);
        #1;
        ifc.req_valid    = 1'b0;
        ifc.write_enable = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        chk("abort_resp_valid_in_rst", 32'(ifc.resp_valid), 32'd0);
        chk("abort_ready_in_rst", 32'(ifc.req_ready), 32'd0);
        rst = 1'b0;
        pulses = 0;
        repeat (6) begin
            @(negedge clk);
            if (ifc.resp_valid) pulses++;
        end
        chk("abort_no_resp", 32'(pulses), 32'd0);
        do_req(32'h30, 1'b1, 1'b0, 4'h0, 32'h0, rd, lat, single, err);
        chk("abort_unchanged", rd, 32'hCAFEF00D);

        // back-to-back reads with req_valid held high
        do_req(32'h0, 1'b0, 1'b1, 4'hF, 32'h0BADF00D, rd, lat, single, err);
        do_req(32'h4, 1'b0, 1'b1, 4'hF, 32'h600DCAFE, rd, lat, single, err);
        do_req(32'h8, 1'b0, 1'b1, 4'hF, 32'h13579BDF, rd, lat, single, err);
        np = 0;
        na = 0;
        ready_hi = 0;
        @(negedge clk);
        ifc.req_valid    = 1'b1;
        ifc.address      = 32'h0;
        ifc.read_enable  = 1'b1;
        ifc.write_enable = 1'b0;
        for (int cyc = 0; cyc < 16; cyc++) begin
            took = ifc.req_valid && ifc.req_ready;
            if (took) ready_hi++;
            if (ifc.resp_valid && np < 3) begin
                pulse_cyc[np] = cyc;
                pulse_dat[np] = ifc.read_data;
                np++;
            end
            @(posedge clk);
            #1;
            if (took) begin
                na++;
                if (na < 3) ifc.address = 32'(na * 4);
                else begin
                    ifc.req_valid   = 1'b0;
                    ifc.read_enable = 1'b0;
                end
            end
            @(negedge clk);
        end
        chk("b2b_accepts", 32'(na), 32'd3);
        chk("b2b_ready_cycles", 32'(ready_hi), 32'd3);
        chk("b2b_pulses", 32'(np), 32'd3);
        chk("b2b_first_pulse", 32'(pulse_cyc[0]), 32'd3);
        chk("b2b_gap01", 32'(pulse_cyc[1] - pulse_cyc[0]), 32'd4);
        chk("b2b_gap12", 32'(pulse_cyc[2] - pulse_cyc[1]), 32'd4);
        chk("b2b_data0", pulse_dat[0], 32'h0BADF00D);
        chk("b2b_data1", pulse_dat[1], 32'h600DCAFE);
        chk("b2b_data2", pulse_dat[2], 32'h13579BDF);

        // address beyond the storage range
        do_req(32'h1000, 1'b0, 1'b1, 4'hF, 32'h12345678, rd, lat, single, err);
        chk("range_latency", 32'(lat), 32'd3);
`ifdef MEM_RANGE_CHECK_EN
        chk("range_err_set", 32'(err), 32'd1);
        do_req(32'h0, 1'b1, 1'b0, 4'h0, 32'h0, rd, lat, single, err);
        chk("range_word0_unchanged", rd, 32'h0BADF00D);
        chk("range_err_clear", 32'(err), 32'd0);
`else
        chk("range_no_err", 32'(err), 32'd0);
        do_req(32'h0, 1'b1, 1'b0, 4'h0, 32'h0, rd, lat, single, err);
        chk("alias_word0", rd, 32'h12345678);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
